stream_window_ctrl: RTL

Sequencing controller for a radius-R neighbourhood filter fed by a raster grayscale pixel stream of WIDTH x HEIGHT. The stream is framed by done_i (high = pixel present on grayscale_i).
- Tracks the position of each pixel entering the datapath.
- Generates the datapath shift enable.
- Runs a zero-padded flush after the last real pixel so every window centre is emitted.
- Reports when the window centred at (out_row_o, out_col_o) is complete.
- Sits between the pixel source and the line-buffer/window datapath. It carries control only; grayscale data does not pass through it.

---
 rtl/stream_window_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stream_window_ctrl.sv
// stream_window_ctrl: sequencing control for a radius-RADIUS neighbourhood filter
// fed by a raster pixel stream. It tracks the entering pixel position, drives the
// datapath shift enable, runs a zero-padded flush after the last pixel, and
// reports each completed window centre. Optional macro STREAM_WINDOW_OVERRUN_EN
// adds a sticky overrun_o flag for input offered while the frame is draining.
module stream_window_ctrl #(
    parameter int WIDTH  = 30,
    parameter int HEIGHT = 30,
    parameter int RADIUS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                done_i,
    output logic                                shift_en_o,
    output logic                                pad_o,
    output logic [$clog2(HEIGHT+RADIUS+1)-1:0]  in_row_o,
    output logic [$clog2(WIDTH)-1:0]            in_col_o,
    output logic                                valid_o,
    output logic [$clog2(HEIGHT)-1:0]           out_row_o,
    output logic [$clog2(WIDTH)-1:0]            out_col_o,
    output logic                                border_o,
    output logic                                busy_o,
    output logic                                frame_done_o
`ifdef STREAM_WINDOW_OVERRUN_EN
    ,
    output logic                                overrun_o
`endif
);
    localparam int IRW       = $clog2(HEIGHT+RADIUS+1);
    localparam int CW        = $clog2(WIDTH);
    localparam int ORW       = $clog2(HEIGHT);
    localparam int FLUSH_LEN = RADIUS*WIDTH + RADIUS;
    localparam int FCW       = $clog2(FLUSH_LEN+1);

    localparam logic [CW-1:0]  COL_LAST     = CW'(WIDTH-1);
    localparam logic [CW-1:0]  COL_R        = CW'(RADIUS);
    localparam logic [IRW-1:0] IN_ROW_LAST  = IRW'(HEIGHT-1);
    localparam logic [IRW-1:0] IN_ROW_R     = IRW'(RADIUS);
    localparam logic [ORW-1:0] OUT_ROW_LAST = ORW'(HEIGHT-1);
    localparam logic [FCW-1:0] FLUSH_LAST   = FCW'(FLUSH_LEN-1);

    // A window wider or taller than the frame has no valid centre sequence.
    if ((2*RADIUS+1 > WIDTH) || (2*RADIUS+1 > HEIGHT)) begin : g_bad_cfg
        $error("stream_window_ctrl: 2*RADIUS+1 exceeds WIDTH or HEIGHT");
    end

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [IRW-1:0]   in_row_q;
    logic [CW-1:0]    in_col_q;
    logic [FCW-1:0]   flush_q;
    logic [ORW-1:0]   oc_row_q;
    logic [CW-1:0]    oc_col_q;
    logic             valid_q, border_q;
    logic [ORW-1:0]   out_row_q;
    logic [CW-1:0]    out_col_q;
    logic             shift_en, pad, last_pix, win_hit;

    function automatic logic is_border(input logic [ORW-1:0] r, input logic [CW-1:0] c);
        return (int'(r) < RADIUS) || (int'(r) > HEIGHT-1-RADIUS) ||
               (int'(c) < RADIUS) || (int'(c) > WIDTH-1-RADIUS);
    endfunction

    assign last_pix = (in_row_q == IN_ROW_LAST) && (in_col_q == COL_LAST);
    // Shift index k >= RADIUS*WIDTH+RADIUS, i.e. the entering pixel is at or past (RADIUS,RADIUS).
    assign win_hit  = shift_en &&
                      ((in_row_q > IN_ROW_R) || ((in_row_q == IN_ROW_R) && (in_col_q >= COL_R)));

    // Next-state and shift/pad decode; reset masks the enables so done_i is ignored.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        pad      = 1'b0;
        case (state_q)
            IDLE: begin
                shift_en = done_i;
                if (done_i) state_d = STREAM;
            end
            STREAM: begin
                shift_en = done_i;
                if (done_i && last_pix) state_d = FLUSH;
            end
            FLUSH: begin
                shift_en = 1'b1;
                pad      = 1'b1;
                if (flush_q == FLUSH_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            shift_en = 1'b0;
            pad      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Entering-pixel row/column and flush length counters; cleared as the frame ends.
    always_ff @(posedge clk) begin
        if (rst || state_q == DONE) begin
            in_row_q <= '0;
            in_col_q <= '0;
            flush_q  <= '0;
        end else if (shift_en) begin
            if (in_col_q == COL_LAST) begin
                in_col_q <= '0;
                in_row_q <= in_row_q + 1'b1;
            end else begin
                in_col_q <= in_col_q + 1'b1;
            end
            if (pad) flush_q <= flush_q + 1'b1;
        end
    end

    // Window-centre counters and the registered completion report; wraps to (0,0) after the last centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            oc_row_q  <= '0;
            oc_col_q  <= '0;
            valid_q   <= 1'b0;
            border_q  <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            valid_q  <= win_hit;
            border_q <= win_hit && is_border(oc_row_q, oc_col_q);
            if (win_hit) begin
                out_row_q <= oc_row_q;
                out_col_q <= oc_col_q;
                if (oc_col_q == COL_LAST) begin
                    oc_col_q <= '0;
                    oc_row_q <= (oc_row_q == OUT_ROW_LAST) ? '0 : oc_row_q + 1'b1;
                end else begin
                    oc_col_q <= oc_col_q + 1'b1;
                end
            end
        end
    end

`ifdef STREAM_WINDOW_OVERRUN_EN
    logic overrun_q;

    // Sticky flag: source offered a pixel while the frame was draining.
    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else if (done_i && (state_q == FLUSH || state_q == DONE)) overrun_q <= 1'b1;
    end

    assign overrun_o = overrun_q;
`endif

    assign shift_en_o   = shift_en;
    assign pad_o        = pad;
    assign in_row_o     = in_row_q;
    assign in_col_o     = in_col_q;
    assign valid_o      = valid_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;
    assign border_o     = border_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = (state_q == DONE);

endmodule
